// File: rtl/vpu_strided_lsu.sv
// Vector load/store engine: one micro-op per vector register, one D$ word access per active
// element (two for SEW64), with the load buffer written back to the regfile in FINISH.
module vpu_strided_lsu #(
    parameter int VLEN    = 128,
    parameter int VL_BITS = $clog2(VLEN / 8) + 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_store_i,
    input  logic                 req_strided_i,
    input  logic [1:0]           req_sew_i,
    input  logic [VL_BITS-1:0]   req_vl_i,
    input  logic                 req_vm_i,
    input  logic [31:0]          req_base_i,
    input  logic [31:0]          req_stride_i,
    input  logic [4:0]           req_vreg_i,
    input  logic [VLEN-1:0]      req_data_i,
    input  logic [VLEN-1:0]      v0_i,
    output logic                 dcache_vpu_request_o,
    output logic [3:0]           dcache_vpu_write_o,
    output logic [31:0]          dcache_vpu_addr_o,
    output logic [31:0]          dcache_vpu_in_o,
    input  logic                 dcache_vpu_wait_i,
    input  logic [31:0]          dcache_vpu_out_i,
    output logic                 vreg_write_en_o,
    output logic [4:0]           vreg_write_addr_o,
    output logic [VLEN/8-1:0]    vreg_write_be_o,
    output logic [VLEN-1:0]      vreg_write_data_o,
    output logic                 done_o,
    output logic                 err_o
);

    localparam int NB = VLEN / 8;
    localparam int IW = $clog2(VLEN);

    typedef enum logic [1:0] {IDLE, ACCESS, FINISH} state_t;

    state_t               state;
    logic                 ready_q;
    logic                 done_q;
    logic                 err_q;
    logic                 wen_q;
    logic                 store_q;
    logic [1:0]           sew_q;
    logic [VL_BITS-1:0]   vl_q;
    logic                 vm_q;
    logic [4:0]           vreg_q;
    logic [VLEN-1:0]      data_q;
    logic [VLEN-1:0]      mask_q;
    logic [31:0]          stride_q;
    logic [31:0]          addr_q;
    logic [VL_BITS-1:0]   elem_q;
    logic                 half_q;
    logic [VLEN-1:0]      buf_q;
    logic [NB-1:0]        be_q;

    logic                 first_err;
    logic                 cur_active;
    logic                 access;
    logic                 complete;
    logic                 last_part;
    logic                 step;
    logic [VL_BITS-1:0]   next_elem;
    logic [31:0]          next_addr;
    logic                 next_active;
    logic                 next_done;
    logic                 next_err;
    logic [1:0]           lane;
    logic [31:0]          word_addr;
    logic [3:0]           strobe;
    logic [63:0]          elem64;
    logic [31:0]          st_word;
    logic [31:0]          ld_word;
    logic [VLEN-1:0]      buf_n;
    logic [NB-1:0]        be_n;

    function automatic logic misaligned(input logic [31:0] a, input logic [1:0] sew);
        case (sew)
            2'd0:    return 1'b0;
            2'd1:    return a[0];
            2'd2:    return |a[1:0];
            default: return |a[2:0];
        endcase
    endfunction

    assign first_err   = (req_vm_i | v0_i[0]) & misaligned(req_base_i, req_sew_i);
    assign cur_active  = vm_q | mask_q[IW'(elem_q)];
    assign access      = (state == ACCESS) && cur_active;
    assign complete    = access && !dcache_vpu_wait_i;
    assign last_part   = (sew_q != 2'd3) || half_q;
    assign step        = (state == ACCESS) && (!cur_active || (complete && last_part));
    assign next_elem   = elem_q + VL_BITS'(1);
    assign next_addr   = addr_q + stride_q;
    assign next_active = vm_q | mask_q[IW'(next_elem)];
    assign next_done   = (next_elem == vl_q);
    assign next_err    = !next_done && next_active && misaligned(next_addr, sew_q);

    // SEW64 addresses are 8-byte aligned, so bit 2 selects the low or high word.
    assign lane      = addr_q[1:0];
    assign word_addr = (sew_q == 2'd3) ? {addr_q[31:3], half_q, 2'b00} : {addr_q[31:2], 2'b00};

    always_comb begin
        int elem_bit;
        elem_bit = int'(elem_q) << (int'(sew_q) + 3);
        elem64   = 64'(data_q >> elem_bit);
        case (sew_q)
            2'd0: begin
                strobe  = 4'b0001 << lane;
                st_word = {4{elem64[7:0]}};
            end
            2'd1: begin
                strobe  = 4'b0011 << lane;
                st_word = {2{elem64[15:0]}};
            end
            2'd2: begin
                strobe  = 4'b1111;
                st_word = elem64[31:0];
            end
            default: begin
                strobe  = 4'b1111;
                st_word = half_q ? elem64[63:32] : elem64[31:0];
            end
        endcase
    end

    // Place the returned element bytes at their position in the destination register.
    always_comb begin
        int off;
        int nbytes;
        buf_n   = buf_q;
        be_n    = be_q;
        off     = (int'(elem_q) << sew_q) + (half_q ? 4 : 0);
        nbytes  = (sew_q == 2'd3) ? 4 : (1 << sew_q);
        ld_word = dcache_vpu_out_i >> {lane, 3'b000};
        for (int b = 0; b < NB; b++) begin
            if (b >= off && b < off + nbytes) begin
                buf_n[b*8 +: 8] = 8'(ld_word >> (8 * (b - off)));
                be_n[b]         = 1'b1;
            end
        end
    end

    assign dcache_vpu_request_o = access;
    assign dcache_vpu_write_o   = (access && store_q) ? strobe : 4'b0000;
    assign dcache_vpu_addr_o    = access ? word_addr : 32'd0;
    assign dcache_vpu_in_o      = (access && store_q) ? st_word : 32'd0;

    assign req_ready_o       = ready_q;
    assign done_o            = done_q;
    assign err_o             = err_q;
    assign vreg_write_en_o   = wen_q;
    assign vreg_write_addr_o = vreg_q;
    assign vreg_write_be_o   = be_q;
    assign vreg_write_data_o = buf_q;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state   <= IDLE;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            wen_q   <= 1'b0;
            elem_q  <= '0;
            half_q  <= 1'b0;
            addr_q  <= '0;
            vreg_q  <= '0;
            buf_q   <= '0;
            be_q    <= '0;
        end else begin
            done_q <= 1'b0;
            wen_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        ready_q  <= 1'b0;
                        store_q  <= req_store_i;
                        sew_q    <= req_sew_i;
                        vl_q     <= req_vl_i;
                        vm_q     <= req_vm_i;
                        vreg_q   <= req_vreg_i;
                        data_q   <= req_data_i;
                        mask_q   <= v0_i;
                        stride_q <= req_strided_i ? req_stride_i : (32'd1 << req_sew_i);
                        addr_q   <= req_base_i;
                        elem_q   <= '0;
                        half_q   <= 1'b0;
                        buf_q    <= '0;
                        be_q     <= '0;
                        if (req_vl_i == '0) begin
                            state  <= FINISH;
                            done_q <= 1'b1;
                        end else if (first_err) begin
                            state  <= FINISH;
                            done_q <= 1'b1;
                            err_q  <= 1'b1;
                        end else begin
                            state <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (complete && !store_q) begin
                        buf_q <= buf_n;
                        be_q  <= be_n;
                    end
                    if (complete && !last_part) begin
                        half_q <= 1'b1;
                    end
                    // The next element's alignment is checked here so no request is ever issued for it.
                    if (step) begin
                        half_q <= 1'b0;
                        elem_q <= next_elem;
                        addr_q <= next_addr;
                        if (next_done || next_err) begin
                            state  <= FINISH;
                            done_q <= 1'b1;
                            err_q  <= next_err;
                            wen_q  <= !store_q && !next_err;
                        end
                    end
                end
                FINISH: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                    err_q   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vpu_strided_lsu.sv
// Self-checking bench for vpu_strided_lsu: directed cases plus randomized micro-ops against a
// byte-level reference model of the element/address/mask rules.
module tb_vpu_strided_lsu;

    localparam int VLEN    = 128;
    localparam int VL_BITS = $clog2(VLEN / 8) + 1;
    localparam int NB      = VLEN / 8;

    logic               clk = 1'b0;
    logic               rst = 1'b0;   // active-low
    logic               req_valid = 1'b0;
    logic               req_ready;
    logic               req_store = 1'b0;
    logic               req_strided = 1'b0;
    logic [1:0]         req_sew = 2'd0;
    logic [VL_BITS-1:0] req_vl = '0;
    logic               req_vm = 1'b1;
    logic [31:0]        req_base = '0;
    logic [31:0]        req_stride = '0;
    logic [4:0]         req_vreg = '0;
    logic [VLEN-1:0]    req_data = '0;
    logic [VLEN-1:0]    v0 = '0;
    logic               dc_req;
    logic [3:0]         dc_wr;
    logic [31:0]        dc_addr;
    logic [31:0]        dc_in;
    logic               dc_wait = 1'b0;
    logic [31:0]        dc_out;
    logic               wen;
    logic [4:0]         waddr;
    logic [NB-1:0]      wbe;
    logic [VLEN-1:0]    wdata;
    logic               done;
    logic               err;

    always #5 clk = ~clk;

    vpu_strided_lsu #(.VLEN(VLEN)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_store_i(req_store),
        .req_strided_i(req_strided), .req_sew_i(req_sew), .req_vl_i(req_vl), .req_vm_i(req_vm),
        .req_base_i(req_base), .req_stride_i(req_stride), .req_vreg_i(req_vreg),
        .req_data_i(req_data), .v0_i(v0),
        .dcache_vpu_request_o(dc_req), .dcache_vpu_write_o(dc_wr), .dcache_vpu_addr_o(dc_addr),
        .dcache_vpu_in_o(dc_in), .dcache_vpu_wait_i(dc_wait), .dcache_vpu_out_i(dc_out),
        .vreg_write_en_o(wen), .vreg_write_addr_o(waddr), .vreg_write_be_o(wbe),
        .vreg_write_data_o(wdata), .done_o(done), .err_o(err)
    );

    // Read-only memory whose byte contents are a hash of the byte address.
    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        logic [31:0] h;
        h = a * 32'h9E3779B1;
        return h[31:24] ^ a[7:0];
    endfunction

    assign dc_out = {mem_byte(dc_addr + 32'd3), mem_byte(dc_addr + 32'd2),
                     mem_byte(dc_addr + 32'd1), mem_byte(dc_addr)};

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  wr;
        logic [31:0] data;
    } acc_t;

    acc_t            exp_q[$];
    acc_t            obs_q[$];
    logic            exp_err;
    logic            exp_wen;
    int              exp_cycles;
    logic [NB-1:0]   exp_be;
    logic [VLEN-1:0] exp_buf;

    int              o_cycles, o_waits;
    logic            o_done, o_err, o_wen;
    logic [NB-1:0]   o_be;
    logic [VLEN-1:0] o_buf;
    logic [4:0]      o_vreg;

    int passed = 0;
    int total  = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        total = total + 1;
        assert (obs === expv) passed = passed + 1;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    endtask

    function automatic logic [31:0] bmask(input logic [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

    // Walks the elements in order: skipped, accessed byte by byte, or stopped on misalignment.
    task automatic model();
        int          nb, al, lane, cnt, bi, parts;
        logic [31:0] a, st, ba;
        acc_t        x;
        nb = 1 << req_sew;
        al = (nb > 4) ? 4 : nb;
        a  = req_base;
        st = req_strided ? req_stride : 32'(nb);
        exp_q.delete();
        exp_err = 1'b0; exp_cycles = 0; exp_be = '0; exp_buf = '0;
        for (int e = 0; e < int'(req_vl); e++) begin
            if (!(req_vm || v0[e])) begin
                exp_cycles++;
            end else if ((a % al) != 0 || (nb == 8 && a[2:0] != 3'd0)) begin
                exp_err = 1'b1;
                break;
            end else begin
                parts = (nb == 8) ? 2 : 1;
                cnt   = (nb == 8) ? 4 : nb;
                for (int p = 0; p < parts; p++) begin
                    ba     = a + 32'(4 * p);
                    lane   = int'(ba[1:0]);
                    x.addr = {ba[31:2], 2'b00};
                    x.wr   = 4'b0000;
                    x.data = 32'd0;
                    for (int k = 0; k < cnt; k++) begin
                        bi = e * nb + 4 * p + k;
                        if (req_store) begin
                            x.wr[lane + k]           = 1'b1;
                            x.data[(lane + k)*8 +: 8] = req_data[bi*8 +: 8];
                        end else begin
                            exp_be[bi]         = 1'b1;
                            exp_buf[bi*8 +: 8] = mem_byte(ba + 32'(k));
                        end
                    end
                    exp_q.push_back(x);
                    exp_cycles++;
                end
            end
            a = a + st;
        end
        exp_cycles++;
        exp_wen = !req_store && !exp_err && (req_vl != '0);
    endtask

    // wmode: 0 = no wait, 1 = random wait, 2 = three wait cycles on the second access
    task automatic run_op(input string tag, input int wmode);
        int              nwait;
        logic            held;
        acc_t            h;
        logic [VLEN-1:0] m;
        model();
        @(posedge clk); #1 req_valid = 1'b1;
        @(negedge clk);
        chk({tag, " ready_before"}, req_ready, 1);
        @(posedge clk); #1 req_valid = 1'b0;
        obs_q.delete();
        o_cycles = 0; o_waits = 0; o_done = 1'b0; nwait = 0; held = 1'b0;
        while (!o_done && o_cycles < 400) begin
            dc_wait = 1'b0;
            if (dc_req) begin
                if (wmode == 1) dc_wait = ($urandom_range(0, 3) == 0);
                else if (wmode == 2 && obs_q.size() == 1 && nwait < 3) begin
                    dc_wait = 1'b1;
                    nwait++;
                end
            end
            @(negedge clk);
            o_cycles++;
            if (held) begin
                chk({tag, " hold_req"}, dc_req, 1);
                chk({tag, " hold_addr"}, dc_addr, h.addr);
                chk({tag, " hold_wr"}, dc_wr, h.wr);
                chk({tag, " hold_data"}, dc_in, h.data);
            end
            held = 1'b0;
            if (dc_req) begin
                h.addr = dc_addr; h.wr = dc_wr; h.data = dc_in;
                if (dc_wait) begin
                    held = 1'b1;
                    o_waits++;
                end else begin
                    obs_q.push_back(h);
                end
            end
            if (done) begin
                o_done = 1'b1; o_err = err; o_wen = wen; o_be = wbe; o_buf = wdata; o_vreg = waddr;
            end
            @(posedge clk); #1;
        end
        dc_wait = 1'b0;
        chk({tag, " done_seen"}, o_done, 1);
        chk({tag, " ready_after"}, req_ready, 1);
        chk({tag, " latency"}, o_cycles, exp_cycles + o_waits);
        chk({tag, " err"}, o_err, exp_err);
        chk({tag, " wen"}, o_wen, exp_wen);
        chk({tag, " n_access"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            chk($sformatf("%s acc%0d_addr", tag, i), obs_q[i].addr, exp_q[i].addr);
            chk($sformatf("%s acc%0d_wr", tag, i), obs_q[i].wr, exp_q[i].wr);
            if (req_store)
                chk($sformatf("%s acc%0d_data", tag, i), obs_q[i].data & bmask(exp_q[i].wr), exp_q[i].data);
        end
        if (exp_wen) begin
            for (int b = 0; b < NB; b++) m[b*8 +: 8] = {8{exp_be[b]}};
            chk({tag, " be"}, o_be, exp_be);
            chk({tag, " wdata"}, o_buf & m, exp_buf);
            chk({tag, " waddr"}, o_vreg, req_vreg);
        end
    endtask

    task automatic set_req(input logic st, input logic strd, input logic [1:0] sew,
                           input int vl, input logic vm, input logic [31:0] base,
                           input logic [31:0] stride, input logic [4:0] vreg);
        req_store = st; req_strided = strd; req_sew = sew; req_vl = VL_BITS'(vl);
        req_vm = vm; req_base = base; req_stride = stride; req_vreg = vreg;
        req_data = {$urandom, $urandom, $urandom, $urandom};
    endtask

    initial begin
        int dpulses, nb, s;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst ready", req_ready, 1);
        chk("rst request", dc_req, 0);
        chk("rst write", dc_wr, 0);
        chk("rst addr", dc_addr, 0);
        chk("rst in", dc_in, 0);
        chk("rst done", done, 0);
        chk("rst err", err, 0);
        chk("rst wen", wen, 0);
        chk("rst waddr", waddr, 0);
        chk("rst be", wbe, 0);
        chk("rst wdata", wdata, 0);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("post_rst ready", req_ready, 1);

        set_req(1'b0, 1'b0, 2'd2, 4, 1'b1, 32'h100, 32'd0, 5'd3);
        run_op("vle32", 0);
        chk("vle32 lat5", o_cycles, 5);
        chk("vle32 beFFFF", o_be, 16'hFFFF);

        set_req(1'b0, 1'b1, 2'd0, 3, 1'b1, 32'h203, 32'hFFFF_FFFE, 5'd7);
        run_op("vlse8", 0);
        chk("vlse8 be7", o_be, 16'h0007);

        set_req(1'b1, 1'b1, 2'd1, 4, 1'b0, 32'h0, 32'd8, 5'd1);
        v0 = 128'b0101;
        run_op("vsse16", 0);
        chk("vsse16 count", obs_q.size(), 2);
        chk("vsse16 wen", o_wen, 0);
        v0 = '0;

        set_req(1'b0, 1'b0, 2'd3, 2, 1'b1, 32'h80, 32'd0, 5'd9);
        run_op("vle64", 2);
        chk("vle64 waits", o_waits, 3);
        chk("vle64 count", obs_q.size(), 4);
        chk("vle64 beFFFF", o_be, 16'hFFFF);

        set_req(1'b0, 1'b0, 2'd1, 4, 1'b1, 32'h101, 32'd0, 5'd2);
        run_op("vle16_mis", 0);
        chk("vle16_mis err", o_err, 1);
        chk("vle16_mis lat1", o_cycles, 1);
        chk("vle16_mis count", obs_q.size(), 0);

        set_req(1'b0, 1'b0, 2'd0, 0, 1'b1, 32'h40, 32'd0, 5'd4);
        run_op("vl0", 0);
        chk("vl0 lat1", o_cycles, 1);

        // vse8 interrupted by reset while in ACCESS
        set_req(1'b1, 1'b0, 2'd0, 8, 1'b1, 32'h40, 32'd0, 5'd4);
        @(posedge clk); #1 req_valid = 1'b1;
        @(posedge clk); #1 req_valid = 1'b0;
        dpulses = 0;
        @(posedge clk); #1 rst = 1'b0;
        if (done) dpulses++;
        @(posedge clk); #1;
        chk("midrst request", dc_req, 0);
        chk("midrst ready", req_ready, 1);
        if (done) dpulses++;
        rst = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (done) dpulses++;
        end
        chk("midrst no_done", dpulses, 0);
        chk("midrst no_wen", wen, 0);

        for (int t = 0; t < 40; t++) begin
            nb = 1 << (t % 4);
            s  = int'($urandom_range(0, 64)) - 32;
            set_req(1'($urandom), 1'($urandom), 2'(t % 4), int'($urandom_range(0, NB / nb)),
                    ($urandom_range(0, 2) != 0), $urandom,
                    ($urandom_range(0, 7) != 0) ? 32'(s * nb) : 32'(s), 5'($urandom));
            if ($urandom_range(0, 7) != 0) req_base = req_base & ~32'((nb > 4 ? 8 : nb) - 1);
            v0 = {$urandom, $urandom, $urandom, $urandom};
            run_op($sformatf("rnd%0d", t), int'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, total);
        $fatal(1);
    end

endmodule
